// File: rtl/clrall_ctrl_pkg.sv
// Shared types and default sizing for the clear-all memory controller.
package clrall_ctrl_pkg;

  localparam int unsigned DEPTH_DEF = 256;
  localparam int unsigned DW_DEF    = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/clrall_ctrl_cnt.sv
// Bounded up-counter for the clear address: load-zero, enable, saturates at DEPTH-1.
module clrall_ctrl_cnt
  import clrall_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [AW-1:0] cnt_o,
  output logic          last_o
);

  localparam logic [AW-1:0] LastVal = AW'(DEPTH - 1);

  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LastVal)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == LastVal);

endmodule

// File: rtl/clrall_ctrl.sv
// Clear-all controller: zero-fills a memory through a port shared with the core,
// the clear sequence always winning arbitration over core accesses.
module clrall_ctrl
  import clrall_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          main_clk_i,
  input  logic          main_rst_an_i,
  input  logic          regf_ctrl_clrall_wbus_i,
  input  logic          regf_ctrl_clrall_wr_i,
  input  logic          regf_ctrl_ena_rval_i,
  output logic          regf_ctrl_busy_rbus_o,
  input  logic          core_req_i,
  input  logic [AW-1:0] core_addr_i,
  input  logic          core_wena_i,
  input  logic [DW-1:0] core_wdata_i,
  output logic          core_gnt_o,
  output logic          mem_ena_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_wena_o,
  output logic [DW-1:0] mem_wdata_o,
  output logic          done_o
);

  state_e        state_q, state_d;
  logic          busy_q, done_q;
  logic          start;
  logic          cnt_clr, cnt_en, cnt_last;
  logic [AW-1:0] cnt;

  assign start = regf_ctrl_clrall_wr_i & regf_ctrl_clrall_wbus_i & regf_ctrl_ena_rval_i;

  // A fresh start always restarts the pass from address 0, even mid-clear or in DONE.
  always_comb begin
    state_d = state_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_CLEAR;
          cnt_clr = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (start) begin
          cnt_clr = 1'b1;
        end else if (!regf_ctrl_ena_rval_i) begin
          state_d = ST_IDLE;
        end else if (cnt_last) begin
          state_d = ST_DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_CLEAR;
          cnt_clr = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
    end
  end

  clrall_ctrl_cnt #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_cnt (
    .clk_i   (main_clk_i),
    .rst_n_i (main_rst_an_i),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .cnt_o   (cnt),
    .last_o  (cnt_last)
  );

  assign core_gnt_o = core_req_i & regf_ctrl_ena_rval_i & (state_q == ST_IDLE);

  always_comb begin
    mem_ena_o   = 1'b0;
    mem_wena_o  = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (state_q == ST_CLEAR) begin
      mem_ena_o  = 1'b1;
      mem_wena_o = 1'b1;
      mem_addr_o = cnt;
    end else if (core_gnt_o) begin
      mem_ena_o   = 1'b1;
      mem_wena_o  = core_wena_i;
      mem_addr_o  = core_addr_i;
      mem_wdata_o = core_wdata_i;
    end
  end

  assign regf_ctrl_busy_rbus_o = busy_q;
  assign done_o                = done_q;

endmodule

// File: tb/tb_clrall_ctrl.sv
// Bench for clrall_ctrl: directed scenarios plus random traffic against a pass-position model.
module tb_clrall_ctrl;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wbus = 1'b0, wr = 1'b0, ena = 1'b0;
  logic          busy;
  logic          req = 1'b0, we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          gnt, m_ena, m_wena, done;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  int n_cmp = 0;
  int n_err = 0;

  // Model: pass_pos = address written this cycle (-1 when no pass running).
  int pass_pos = -1;
  bit done_now = 1'b0;

  always #5 clk = ~clk;

  clrall_ctrl #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) dut (
    .main_clk_i              (clk),
    .main_rst_an_i           (rst_n),
    .regf_ctrl_clrall_wbus_i (wbus),
    .regf_ctrl_clrall_wr_i   (wr),
    .regf_ctrl_ena_rval_i    (ena),
    .regf_ctrl_busy_rbus_o   (busy),
    .core_req_i              (req),
    .core_addr_i             (addr),
    .core_wena_i             (we),
    .core_wdata_i            (wdata),
    .core_gnt_o              (gnt),
    .mem_ena_o               (m_ena),
    .mem_addr_o              (m_addr),
    .mem_wena_o              (m_wena),
    .mem_wdata_o             (m_wdata),
    .done_o                  (done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_edge();
    bit start;
    bit nd;
    if (!rst_n) begin
      pass_pos = -1;
      done_now = 1'b0;
    end else begin
      start = wr & wbus & ena;
      nd    = 1'b0;
      if (start) begin
        pass_pos = 0;
      end else if (pass_pos >= 0) begin
        if (!ena) begin
          pass_pos = -1;
        end else if (pass_pos == int'(DEPTH) - 1) begin
          pass_pos = -1;
          nd       = 1'b1;
        end else begin
          pass_pos++;
        end
      end
      done_now = nd;
    end
  endtask

  task automatic check_outputs();
    bit clr_act, idle, g;
    clr_act = (pass_pos >= 0);
    idle    = !clr_act && !done_now;
    g       = req & ena & idle;
    chk("busy", 32'(busy), 32'(!idle));
    chk("done", 32'(done), 32'(done_now));
    chk("gnt", 32'(gnt), 32'(g));
    if (clr_act) begin
      chk("mem_ena", 32'(m_ena), 32'd1);
      chk("mem_wena", 32'(m_wena), 32'd1);
      chk("mem_addr", 32'(m_addr), 32'(pass_pos));
      chk("mem_wdata", 32'(m_wdata), 32'd0);
    end else if (g) begin
      chk("mem_ena", 32'(m_ena), 32'd1);
      chk("mem_wena", 32'(m_wena), 32'(we));
      chk("mem_addr", 32'(m_addr), 32'(addr));
      chk("mem_wdata", 32'(m_wdata), 32'(wdata));
    end else begin
      chk("mem_ena", 32'(m_ena), 32'd0);
      chk("mem_wena", 32'(m_wena), 32'd0);
      chk("mem_addr", 32'(m_addr), 32'd0);
      chk("mem_wdata", 32'(m_wdata), 32'd0);
    end
  endtask

  // One clock: update the model with the inputs the DUT just sampled, drive, then check.
  task automatic step(input bit r, input bit wr_v, input bit wb_v, input bit en_v,
                      input bit rq_v, input bit we_v, input logic [AW-1:0] a_v,
                      input logic [DW-1:0] d_v);
    @(posedge clk);
    model_edge();
    #1;
    rst_n = r;
    wr    = wr_v;
    wbus  = wb_v;
    ena   = en_v;
    req   = rq_v;
    we    = we_v;
    addr  = a_v;
    wdata = d_v;
    if (!r) begin
      pass_pos = -1;
      done_now = 1'b0;
    end
    #1;
    check_outputs();
  endtask

  task automatic idle_n(input int n, input bit en_v);
    for (int i = 0; i < n; i++) step(1, 0, 0, en_v, 0, 0, '0, '0);
  endtask

  initial begin
    // Reset state.
    step(0, 0, 0, 1, 0, 0, '0, '0);
    step(0, 0, 0, 1, 0, 0, '0, '0);
    step(1, 0, 0, 1, 0, 0, '0, '0);

    // Full clear from idle.
    step(1, 1, 1, 1, 0, 0, '0, '0);
    idle_n(12, 1);

    // Restart at cycle 4 of a pass.
    step(1, 1, 1, 1, 0, 0, '0, '0);
    idle_n(3, 1);
    step(1, 1, 1, 1, 0, 0, '0, '0);
    idle_n(12, 1);

    // Enable dropped at cycle 3.
    step(1, 1, 1, 1, 0, 0, '0, '0);
    idle_n(2, 1);
    step(1, 0, 0, 0, 0, 0, '0, '0);
    idle_n(4, 1);

    // Core request held across a clear.
    step(1, 1, 1, 1, 1, 1, 3'd5, 16'hBEEF);
    for (int i = 0; i < 12; i++) step(1, 0, 0, 1, 1, 1, 3'd5, 16'hBEEF);
    step(1, 0, 0, 1, 1, 0, 3'd2, 16'h1234);

    // Ignored starts.
    step(1, 1, 0, 1, 0, 0, '0, '0);
    step(1, 1, 1, 0, 0, 0, '0, '0);
    idle_n(3, 1);

    // Start while DONE.
    step(1, 1, 1, 1, 0, 0, '0, '0);
    idle_n(8, 1);
    step(1, 1, 1, 1, 0, 0, '0, '0);
    idle_n(12, 1);

    // Reset mid-clear.
    step(1, 1, 1, 1, 0, 0, '0, '0);
    idle_n(4, 1);
    step(0, 0, 0, 1, 0, 0, '0, '0);
    step(1, 0, 0, 1, 0, 0, '0, '0);
    idle_n(12, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit r_v, rq_v;
      r_v  = ($urandom_range(0, 99) != 0);
      rq_v = r_v ? ($urandom_range(0, 1) == 1) : 1'b0;
      step(r_v,
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 29) != 0),
           rq_v,
           ($urandom_range(0, 1) == 1),
           AW'($urandom_range(0, DEPTH - 1)),
           DW'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/clrall_ctrl.md
CLRALL_CTRL -- requirements
Module: clrall_ctrl

Interface
REQ-001 Parameter: DEPTH, default 256, number of memory words cleared; legal range 2..8192.
REQ-002 Parameter: DW, default 32, memory data width.
REQ-003 Parameter: AW, default clog2(DEPTH), memory address width (derived).
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 main_clk_i  in  1  clock.
REQ-006 main_rst_an_i  in  1  async reset, active-low.
REQ-007 regf_ctrl_clrall_wbus_i  in  1  bus write value of ctrl.clrall.
REQ-008 regf_ctrl_clrall_wr_i  in  1  bus write strobe of ctrl.clrall.
REQ-009 regf_ctrl_ena_rval_i  in  1  block enable (ctrl.ena).
REQ-010 regf_ctrl_busy_rbus_o  out  1  clear in progress, read back as ctrl.busy.
REQ-011 core_req_i  in  1  core memory access request.
REQ-012 core_addr_i  in  AW  core address.
REQ-013 core_wena_i  in  1  core write enable (0 = read).
REQ-014 core_wdata_i  in  DW  core write data.
REQ-015 core_gnt_o  out  1  core access accepted this cycle.
REQ-016 mem_ena_o / mem_addr_o / mem_wena_o / mem_wdata_o  out  1/AW/1/DW  shared memory port.
REQ-017 done_o  out  1  single-cycle pulse on clear completion.

Function
REQ-018 FSM states: IDLE, CLEAR, DONE; state register drives busy and done.
REQ-019 Start condition: clrall_wr_i=1 AND clrall_wbus_i=1 AND ena_rval_i=1; clrall_wr_i with wbus=0 is ignored.
REQ-020 IDLE -> CLEAR on start; address counter loads 0.
REQ-021 In CLEAR each cycle: mem_ena_o=1, mem_wena_o=1, mem_addr_o=counter, mem_wdata_o=0; counter increments by 1.
REQ-022 CLEAR -> DONE in the cycle the write to address DEPTH-1 is issued; counter never wraps past DEPTH-1.
REQ-023 DONE: done_o=1 for exactly one cycle, no memory access, then -> IDLE.
REQ-024 Timing: start in cycle 0 -> writes to addresses 0..DEPTH-1 in cycles 1..DEPTH, done_o=1 in cycle DEPTH+1.
REQ-025 regf_ctrl_busy_rbus_o = 1 in CLEAR and DONE, 0 in IDLE; registered output.
REQ-026 Start during CLEAR: counter restarts at 0, state remains CLEAR, no done_o for the aborted pass.
REQ-027 Start during DONE: done_o still pulses; next state is CLEAR with counter 0.
REQ-028 ena_rval_i=0 in CLEAR: abort -> IDLE next cycle, no further writes, done_o stays 0.
REQ-029 core_gnt_o = core_req_i AND ena_rval_i AND state==IDLE (combinational); the clear has absolute priority.
REQ-030 When granted: mem port carries core_addr_i/core_wena_i/core_wdata_i with mem_ena_o=1 in the same cycle.
REQ-031 Start and core_req_i in the same IDLE cycle: core is granted in that cycle, clear begins next cycle.
REQ-032 No grant and not CLEAR: mem_ena_o=0, mem_wena_o=0, mem_addr_o=0, mem_wdata_o=0.
REQ-033 Memory read data is not routed through this block.

Reset
REQ-034 Reset state: IDLE, counter 0, busy 0, done_o 0, mem_ena_o 0, core_gnt_o 0.
REQ-035 Reset asserted mid-CLEAR aborts immediately; no done_o follows release.

Structure
REQ-036 Shared package clrall_ctrl_pkg holds FSM state enum (IDLE, CLEAR, DONE) and the default DEPTH/DW constants.
REQ-037 Sub-module clrall_ctrl_cnt: bounded up-counter with load-zero, enable and last-value flag; the rest stays flat.

Verification
REQ-038 DEPTH=8, start at cycle 0 -> writes of 0 to addr 0..7 in cycles 1..8, busy 1 in cycles 1..9, done_o=1 only in cycle 9.
REQ-039 DEPTH=8, second start at cycle 4 -> addr sequence 0,1,2,3,0..7, single done_o after the last write to addr 7.
REQ-040 ena_rval_i dropped at cycle 3 of a clear -> last write addr 2, busy 0 at cycle 4, no done_o.
REQ-041 core_req_i held high during a clear -> core_gnt_o=0 throughout busy, core_gnt_o=1 in first IDLE cycle with core address on mem port.
REQ-042 clrall_wr_i=1 with clrall_wbus_i=0, or with ena_rval_i=0 -> no state change, busy stays 0.
REQ-043 Reset pulse at cycle 5 of a clear -> all outputs 0 and no further writes after release, no done_o.
